// File: rtl/commutation_scheduler.sv
// Sequences commutation load requests A/B/C across a programmable switching period.
// Latency: outputs registered, change on the edge that starts each counter cycle.
// Backpressure: none; enable is sampled every clock, period parameters at period start.
module commutation_scheduler #(
    parameter int CNT_W     = 12,
    parameter int MIN_DWELL = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] t_a,
    input  logic [CNT_W-1:0] t_b,
    output logic [1:0]       desired_load,
    output logic             period_tick,
    output logic             fault,
    output logic             busy
);
    localparam logic [1:0]     LOAD_A = 2'b01;
    localparam logic [1:0]     LOAD_B = 2'b10;
    localparam logic [1:0]     LOAD_C = 2'b11;
    localparam logic [CNT_W:0] DWELL  = (CNT_W+1)'(MIN_DWELL);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] ta_s;
    logic [CNT_W-1:0] tb_s;
    logic [CNT_W-1:0] tc_s;

    logic [CNT_W:0]   ab_sum;
    logic [CNT_W:0]   tc_full;
    logic             in_valid;
    logic             at_wrap;
    logic             period_edge;
    logic             do_start;
    logic             do_fault;
    logic [CNT_W-1:0] cnt_nx;

    // Segment in force at counter c: the last active segment whose start has been
    // reached, or the first active one while leading segments are skipped.
    function automatic logic [1:0] seg_at(input logic [CNT_W-1:0] c,
                                          input logic [CNT_W-1:0] ta,
                                          input logic [CNT_W-1:0] tb,
                                          input logic [CNT_W-1:0] tc);
        logic [CNT_W:0] b_start;
        logic [CNT_W:0] c_start;
        logic           a_on;
        logic           b_on;
        logic           c_on;
        logic [1:0]     r;
        b_start = {1'b0, ta};
        c_start = {1'b0, ta} + {1'b0, tb};
        a_on    = {1'b0, ta} >= DWELL;
        b_on    = {1'b0, tb} >= DWELL;
        c_on    = {1'b0, tc} >= DWELL;
        r       = a_on ? LOAD_A : (b_on ? LOAD_B : LOAD_C);
        if (b_on && {1'b0, c} >= b_start) r = LOAD_B;
        if (c_on && {1'b0, c} >= c_start) r = LOAD_C;
        return r;
    endfunction

    always_comb begin
        ab_sum   = {1'b0, t_a} + {1'b0, t_b};
        tc_full  = {1'b0, period} - ab_sum;
        in_valid = (ab_sum <= {1'b0, period}) &&
                   ({1'b0, t_a} >= DWELL || {1'b0, t_b} >= DWELL || tc_full >= DWELL);
    end

    assign at_wrap     = (cnt == period_s - CNT_W'(1));
    assign cnt_nx      = cnt + CNT_W'(1);
    assign period_edge = enable && ((state == IDLE) || (state == RUN && at_wrap));
    assign do_start    = period_edge && in_valid;
    assign do_fault    = period_edge && !in_valid;

    always_ff @(posedge clk) begin
        period_tick <= 1'b0;
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period_s     <= '0;
            ta_s         <= '0;
            tb_s         <= '0;
            tc_s         <= '0;
            desired_load <= 2'b00;
            fault        <= 1'b0;
            busy         <= 1'b0;
        end else if (do_start) begin
            state        <= RUN;
            busy         <= 1'b1;
            cnt          <= '0;
            period_tick  <= 1'b1;
            period_s     <= period;
            ta_s         <= t_a;
            tb_s         <= t_b;
            tc_s         <= tc_full[CNT_W-1:0];
            desired_load <= seg_at('0, t_a, t_b, tc_full[CNT_W-1:0]);
        end else if (do_fault) begin
            // desired_load is deliberately left alone to keep a conducting path
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (at_wrap) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt          <= cnt_nx;
                        desired_load <= seg_at(cnt_nx, ta_s, tb_s, tc_s);
                    end
                end
                FAULT: begin
                    if (!enable) begin
                        state <= IDLE;
                        fault <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/commutation_scheduler.md
COMMUTATION_SCHEDULER -- requirements
Module: commutation_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of period/duration inputs and internal counter.
REQ-002 SHALL have parameter MIN_DWELL, default 13, minimum clocks between any two desired_load changes (covers TDOFF+TDON+margin of the commutation FSM).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  run request; sampled every clock.
REQ-006 SHALL have port period  input  CNT_W  switching period length in clocks.
REQ-007 SHALL have port t_a  input  CNT_W  duration of load-A segment in clocks.
REQ-008 SHALL have port t_b  input  CNT_W  duration of load-B segment; load-C duration = period - t_a - t_b.
REQ-009 SHALL have port desired_load  output  2  registered load request to commutation FSM: 01=A, 10=B, 11=C, 00=NUL.
REQ-010 SHALL have port period_tick  output  1  one-cycle pulse in the first cycle of every period.
REQ-011 SHALL have port fault  output  1  registered, high while in FAULT.
REQ-012 SHALL have port busy  output  1  high while in RUN.

Function
REQ-013 SHALL implement states IDLE, RUN, FAULT.
REQ-014 SHALL sample period/t_a/t_b into shadow registers only on period start (IDLE->RUN edge or wrap edge); input changes mid-period have no effect until the next period.
REQ-015 SHALL compute t_c = period - t_a - t_b at CNT_W+1 bits, no wraparound; sample valid iff t_a+t_b <= period and at least one of t_a, t_b, t_c >= MIN_DWELL.
REQ-016 SHALL, in IDLE with enable=1 at edge k: if sample valid, enter RUN, counter=0, period_tick=1 and desired_load = first active segment from edge k; if invalid, enter FAULT.
REQ-017 SHALL treat a segment as active iff its duration >= MIN_DWELL; order within a period is A, B, C.
REQ-018 SHALL drive first active segment from counter 0; leading skipped segments extend it.
REQ-019 SHALL switch desired_load only at the counter boundary (t_a, t_a+t_b) that starts an active segment; skipped segments extend the preceding active segment.
REQ-020 SHALL wrap counter from period_s-1 to 0 so each period lasts exactly period_s clocks; at wrap, resample and apply REQ-016 validity (invalid -> FAULT).
REQ-021 SHALL guarantee no two desired_load changes closer than MIN_DWELL clocks, including across period wrap; if the new first segment equals the last one, no change occurs.
REQ-022 SHALL, on enable=0 during RUN, complete the current period and enter IDLE at the wrap edge instead of restarting; period_tick not asserted then.
REQ-023 SHALL hold desired_load at its last value in IDLE and FAULT (never force NUL after first run, to keep a conducting path).
REQ-024 SHALL leave FAULT to IDLE only when enable=0 is sampled; fault deasserts on that edge.
REQ-025 SHALL give period_tick precedence-free behaviour: asserted exactly one cycle per period start, never in IDLE/FAULT.

Reset
REQ-026 SHALL on rst=1 at any edge, including mid-period: state=IDLE, counter=0, shadows=0, desired_load=00, period_tick=0, fault=0, busy=0.
REQ-027 SHALL give rst priority over enable and all other inputs on the same edge.

Verification
REQ-028 SHALL test nominal: MIN_DWELL=13, period=100, t_a=30, t_b=20, enable=1 -> A cycles 0-29, B 30-49, C 50-99, period_tick every 100 clocks.
REQ-029 SHALL test skip: period=100, t_a=5, t_b=40 -> B cycles 0-44, C 45-99; no A ever driven; all changes >= 13 apart.
REQ-030 SHALL test fault: period=100, t_a=60, t_b=50 -> fault=1, busy=0, desired_load held; enable=0 -> IDLE, fault=0.
REQ-031 SHALL test shadowing and enable drop: change t_a 30->70 at cycle 40, drop enable at cycle 60 -> current period unchanged (C to 99), IDLE at wrap, desired_load stays 11.
REQ-032 SHALL test reset mid-run: rst=1 at cycle 35 -> next cycle desired_load=00, busy=0, counter=0; re-enable restarts at A.
